uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter that sits directly downstream of the decimal stdout formatter. It accepts ASCII bytes over a valid/ready handshake into a small FIFO and serializes them as 8N1 frames on `tx_o`. It reports host availability from the hardware flow-control input `cts_ni`, so the formatter drops output when no host is listening.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = CLK_HZ / BAUD`, truncated; a `DIV < 2` configuration is illegal (elaboration error).
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `val_i` input 1: byte valid from the formatter.
- `data_i` input 8: byte to send.
- `rdy_o` output 1: byte accepted this cycle when `val_i & rdy_o`.
- `avail_o` output 1: host present (synchronized, inverted `cts_ni`).
- `cts_ni` input 1: clear-to-send from host, active-low, asynchronous to `clk_i`.
- `tx_o` output 1: serial line; idles high.
- `busy_o` output 1: FIFO non-empty or frame in progress.

## Operation
- Reset values:
  - `tx_o` = 1; `rdy_o` = 0; `avail_o` = 0; `busy_o` = 0.
  - FIFO is empty; state is IDLE.
  - Synchronizer flops reset to 1, meaning the host is deasserted.
- CTS synchronizer:
  - Two flops on `cts_ni`.
  - `avail_o` is the inverted output of the second flop.
- Handshake rule: `rdy_o = avail_o & ~full`.
  - A push happens when `val_i & rdy_o`, and the byte is written at that clock edge.
  - `rdy_o` does not depend on `val_i`.
- FIFO:
  - Circular buffer with read and write pointers of width log2(DEPTH)+1.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
  - Pointers wrap naturally.
- Serializer states, all registered:
  - IDLE: `tx_o` = 1.
  - START: `tx_o` = 0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each. A 3-bit bit index counts 0..7.
  - STOP: `tx_o` = 1 for DIV cycles.
- Baud counter: counts 0..DIV-1 within each bit. It resets to 0 on every state or bit change.
- Pop condition: FIFO non-empty and `avail_o`, while in IDLE or in the last cycle of STOP.
  - The popped byte is loaded into the shift register.
  - The state moves to START.
- Back-to-back frames have no idle gap between STOP and the next START.
- `busy_o = (state != IDLE) | ~empty`.

## Timing
- Frame length is exactly 10*DIV cycles.
- Latency with an empty FIFO in IDLE and `avail_o` = 1:
  - Byte pushed at edge E0.
  - Popped at edge E1.
  - `tx_o` falls at E1 and stays low through E1+DIV.
- Simultaneous push and pop:
  - Both are legal in the same cycle, including when the FIFO holds DEPTH-1 entries.
  - Occupancy is unchanged.
- Full FIFO: `rdy_o` is low. After a pop, `rdy_o` rises in the following cycle, not combinationally.
- `avail_o` falls (host leaves):
  - A frame in progress completes unchanged.
  - No new pop occurs.
  - FIFO contents are retained and `rdy_o` drops.
  - Transmission resumes when `avail_o` returns.
- `avail_o` lags `cts_ni` by 2–3 cycles.
- `data_i` is sampled only at push. Later changes do not affect queued bytes.
- Reset asserted mid-frame:
  - `tx_o` returns to 1 immediately (asynchronous).
  - FIFO is emptied and the partial frame is abandoned.
- With `val_i` held high and the FIFO full, no byte is dropped or duplicated. Every accepted byte appears on the line exactly once, in order.

## Test plan
1. CLK_HZ=10, BAUD=1 (DIV=10), `cts_ni`=0, push 0x41 into an idle block:
   - `tx_o` sequence from E1 is 0, 1,0,0,0,0,0,1,0, 1.
   - Each level lasts 10 cycles.
   - `busy_o` drops after 100 cycles.
2. Push "1234\n" continuously with DEPTH=4:
   - `rdy_o` deasserts when full.
   - The line carries five contiguous frames with no idle gap.
   - Decoded bytes are 0x31 0x32 0x33 0x34 0x0A.
3. `cts_ni`=1 from reset:
   - `rdy_o` and `avail_o` stay 0.
   - `tx_o` stays 1.
   - Offered bytes are never accepted.
4. Raise `cts_ni` at the 3rd data bit of frame 1 while 3 bytes are queued:
   - Frame 1 completes.
   - `tx_o` then holds 1 and `busy_o` stays 1.
   - Drop `cts_ni`: the remaining 3 bytes are sent in order.
5. Assert `rst_ni`=0 during the DATA state:
   - `tx_o`=1 and `rdy_o`=0 immediately.
   - After release with `cts_ni`=0, `rdy_o` rises within 3 cycles.
   - No stale byte is ever transmitted.
6. Push and pop in the same cycle with 3 of 4 entries occupied:
   - Occupancy stays 3 and `rdy_o` stays 1.
   - Byte order is preserved across pointer wrap-around (push 16 bytes total).

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte FIFO plus 8N1 serializer with CTS-gated transmission
//
// Parameters:
//   CLK_HZ  clock frequency in Hz
//   BAUD    line rate; DIV = CLK_HZ / BAUD cycles per bit (must be >= 2)
//   DEPTH   FIFO entries (power of 2, >= 2)
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   val_i    byte valid from the upstream formatter
//   data_i   byte to queue, sampled only when val_i & rdy_o
//   rdy_o    FIFO can accept a byte (host present and FIFO not full)
//   avail_o  host present: synchronized, inverted cts_ni
//   cts_ni   clear-to-send from the host, active-low, asynchronous
//   tx_o     serial line, idles high
//   busy_o   FIFO non-empty or a frame is on the line

module uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       val_i,
    input  logic [7:0] data_i,
    output logic       rdy_o,
    output logic       avail_o,
    input  logic       cts_ni,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: CLK_HZ / BAUD must be at least 2");
    end

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx: DEPTH must be a power of 2 and at least 2");
    end

    // CTS synchronizer; flops reset to 1 so the host reads as absent
    logic cts_q1, cts_q2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cts_q1 <= 1'b1;
            cts_q2 <= 1'b1;
        end else begin
            cts_q1 <= cts_ni;
            cts_q2 <= cts_q1;
        end
    end

    assign avail_o = ~cts_q2;

    // FIFO: extra pointer MSB distinguishes full from empty
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdy_o = avail_o & ~full;
    assign push  = val_i & rdy_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

    // Serializer
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end, can_pop;

    assign bit_end = (cnt_q == CNT_LAST);
    assign can_pop = ~empty & avail_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx_o is a
    // clean registered output that changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    shift_d = mem[rd_ptr[AW-1:0]];
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame with no idle gap
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        shift_d = mem[rd_ptr[AW-1:0]];
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a line decoder and byte queue model

module tb_uart_tx;

    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       val_i  = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       cts_ni = 1'b0;
    logic       rdy_o, avail_o, tx_o, busy_o;

    uart_tx #(.CLK_HZ(10), .BAUD(1), .DEPTH(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .val_i   (val_i),
        .data_i  (data_i),
        .rdy_o   (rdy_o),
        .avail_o (avail_o),
        .cts_ni  (cts_ni),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Model: bytes accepted, in order, that must appear on the line
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         rx_count = 0;
    bit         in_frame = 0;
    int         mcnt     = 0;
    logic [9:0] rx_bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples each bit at its midpoint from the falling start edge
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            in_frame = 0;
        end else if (!in_frame) begin
            if (tx_o === 1'b0) begin
                in_frame = 1;
                mcnt     = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mcnt++;
            if (mcnt % DIV == DIV / 2) begin
                rx_bits[mcnt / DIV] = tx_o;
                if (mcnt / DIV == 9) begin
                    logic have;
                    in_frame = 0;
                    rx_count++;
                    chk("start_bit", {31'd0, rx_bits[0]}, 32'd0);
                    chk("stop_bit", {31'd0, rx_bits[9]}, 32'd1);
                    have = (exp_q.size() != 0);
                    chk("frame_expected", {31'd0, have}, 32'd1);
                    if (have) chk("rx_byte", {24'd0, rx_bits[8:1]}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b, output int t, output int waited);
        waited = 0;
        @(negedge clk_i);
        val_i  = 1'b1;
        data_i = b;
        while (rdy_o !== 1'b1 && waited < 4 * FRAME) begin
            @(negedge clk_i);
            waited++;
        end
        chk("push_timeout", {31'd0, waited >= 4 * FRAME}, 32'd0);
        @(posedge clk_i);
        #1;
        t      = cyc;
        val_i  = 1'b0;
        data_i = 8'($urandom);
        if (waited < 4 * FRAME) exp_q.push_back(b);
    endtask

    // val_i held high throughout; a byte changes only after being accepted
    task automatic stream(input int n);
        int   i;
        int   w;
        logic acc;
        i = 0;
        w = 0;
        @(negedge clk_i);
        val_i  = 1'b1;
        data_i = 8'($urandom);
        while (i < n && w < n * FRAME * 2) begin
            acc = rdy_o;
            @(posedge clk_i);
            if (acc) begin
                exp_q.push_back(data_i);
                i++;
            end
            @(negedge clk_i);
            if (acc) data_i = 8'($urandom);
            w++;
        end
        val_i = 1'b0;
        chk("stream_count", i, n);
    endtask

    task automatic wait_idle(input int bound);
        int w;
        w = 0;
        while ((busy_o !== 1'b0 || in_frame) && w < bound) begin
            @(negedge clk_i);
            w++;
        end
        chk("drain_timeout", {31'd0, w >= bound}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0, wt, rx0, s0;
        logic [9:0] frame;
        logic [7:0] msg [5];
        logic [7:0] b;

        // Reset state
        rst_ni = 1'b0;
        cts_ni = 1'b0;
        repeat (3) tick();
        chk("rst_tx", {31'd0, tx_o}, 32'd1);
        chk("rst_rdy", {31'd0, rdy_o}, 32'd0);
        chk("rst_avail", {31'd0, avail_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) tick();
        chk("post_rst_avail", {31'd0, avail_o}, 32'd1);
        chk("post_rst_rdy", {31'd0, rdy_o}, 32'd1);

        // Single frame 0x41: exact line waveform and busy timing
        push(8'h41, t0, wt);
        frame = {1'b1, 8'h41, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            tick();
            chk("t1_tx_level", {31'd0, tx_o}, {31'd0, frame[c / DIV]});
        end
        chk("t1_busy_last", {31'd0, busy_o}, 32'd1);
        tick();
        chk("t1_busy_done", {31'd0, busy_o}, 32'd0);
        chk("t1_tx_idle", {31'd0, tx_o}, 32'd1);
        wait_idle(FRAME);

        // "1234\n" back to back: fills the FIFO, no gaps between frames
        msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h0A;
        s0 = start_q.size();
        push(msg[0], t0, wt);
        for (int i = 1; i < 5; i++) push(msg[i], wt, wt);
        chk("t2_full_rdy", {31'd0, rdy_o}, 32'd0);
        while (cyc < t0 + FRAME) @(negedge clk_i);
        chk("t2_rdy_before_pop", {31'd0, rdy_o}, 32'd0);
        tick();
        chk("t2_rdy_after_pop", {31'd0, rdy_o}, 32'd1);
        wait_idle(8 * FRAME);
        chk("t2_frames", start_q.size() - s0, 5);
        for (int i = 1; i < 5 && s0 + i < start_q.size(); i++)
            chk("t2_gap", start_q[s0 + i] - start_q[s0 + i - 1], FRAME);

        // Push and pop on the same edge with 3 of 4 entries held, then wrap
        rx0 = rx_count;
        push(8'($urandom), t0, wt);
        for (int i = 0; i < 3; i++) push(8'($urandom), wt, wt);
        while (cyc < t0 + FRAME) @(negedge clk_i);
        b      = 8'($urandom);
        val_i  = 1'b1;
        data_i = b;
        chk("t6_rdy_before", {31'd0, rdy_o}, 32'd1);
        tick();
        val_i = 1'b0;
        exp_q.push_back(b);
        chk("t6_rdy_after", {31'd0, rdy_o}, 32'd1);
        push(8'($urandom), wt, wt);
        chk("t6_push_nowait", wt, 0);
        chk("t6_full_after", {31'd0, rdy_o}, 32'd0);
        stream(10);
        wait_idle(20 * FRAME);
        chk("t6_rx_count", rx_count - rx0, 16);

        // Host leaves mid-frame: frame completes, queue held, then resumes
        rx0 = rx_count;
        push(8'($urandom), t0, wt);
        for (int i = 0; i < 3; i++) push(8'($urandom), wt, wt);
        while (cyc < t0 + 1 + 3 * DIV + 3) @(negedge clk_i);
        cts_ni = 1'b1;
        repeat (4) tick();
        chk("t4_avail_low", {31'd0, avail_o}, 32'd0);
        chk("t4_rdy_low", {31'd0, rdy_o}, 32'd0);
        while (cyc < t0 + 1 + 2 * FRAME) @(negedge clk_i);
        chk("t4_one_frame", rx_count - rx0, 1);
        chk("t4_tx_hold", {31'd0, tx_o}, 32'd1);
        chk("t4_busy_hold", {31'd0, busy_o}, 32'd1);
        chk("t4_no_frame", {31'd0, in_frame}, 32'd0);
        cts_ni = 1'b0;
        wait_idle(6 * FRAME);
        chk("t4_resumed", rx_count - rx0, 4);

        // Reset during DATA: line idles at once, stale bytes discarded
        push(8'($urandom), t0, wt);
        push(8'($urandom), wt, wt);
        push(8'($urandom), wt, wt);
        while (cyc < t0 + 1 + 3 * DIV + 5) tick();
        rst_ni = 1'b0;
        #1;
        chk("t5_tx_reset", {31'd0, tx_o}, 32'd1);
        chk("t5_rdy_reset", {31'd0, rdy_o}, 32'd0);
        chk("t5_busy_reset", {31'd0, busy_o}, 32'd0);
        exp_q.delete();
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        rx0 = rx_count;
        wt  = 0;
        while (rdy_o !== 1'b1 && wt < 3) begin
            tick();
            wt++;
        end
        chk("t5_rdy_within3", {31'd0, rdy_o}, 32'd1);
        push(8'($urandom), wt, wt);
        wait_idle(4 * FRAME);
        chk("t5_only_new", rx_count - rx0, 1);

        // Random bytes with random gaps
        rx0 = rx_count;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            push(8'($urandom), wt, wt);
        end
        wait_idle(30 * FRAME);
        chk("rand_rx_count", rx_count - rx0, 20);

        // Host absent from reset: nothing accepted, line stays idle
        rst_ni = 1'b0;
        cts_ni = 1'b1;
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        val_i  = 1'b1;
        data_i = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("t3_rdy", {31'd0, rdy_o}, 32'd0);
            chk("t3_avail", {31'd0, avail_o}, 32'd0);
            chk("t3_tx", {31'd0, tx_o}, 32'd1);
        end
        chk("t3_busy", {31'd0, busy_o}, 32'd0);
        val_i = 1'b0;

        chk("model_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
